// File: rtl/mag_peak_detector.sv
// mag_peak_detector
//   Consumes a stream of unsigned magnitudes over a valid/ready handshake.
//   A start pulse arms one frame. The block then collects FRAME_LEN samples,
//   tracks the largest magnitude and the index of its first occurrence, and
//   holds that result on a valid/ready output until the consumer takes it.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   start                  arms a new frame (honoured only in IDLE)
//   mag_in, in_valid       sample input
//   in_ready               high in COLLECT
//   peak_mag, peak_idx     frame result (held through IDLE)
//   peak_valid, out_ready  result handshake
//   busy                   high in COLLECT and DONE
//   thresh, over_cnt       only when MAG_THRESH_EN is defined: a count of
//                          accepted samples with mag_in >= thresh
//
// Build option: MAG_THRESH_EN adds the threshold counter.

module mag_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mag_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] peak_mag,
  output logic [IDX_W-1:0]  peak_idx,
  output logic              peak_valid,
  input  logic              out_ready,
`ifdef MAG_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
  output logic [IDX_W:0]    over_cnt,
`endif
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_peak_mag;
  logic [IDX_W-1:0]  r_peak_idx;
  logic              w_accept;
  logic              w_arm;
  logic              w_load;

  assign w_accept = (r_state == S_COLLECT) && in_valid;
  assign w_arm    = (r_state == S_IDLE) && start;
  // Sample 0 always loads. Later samples load only when strictly larger, so a
  // tie keeps the earliest index.
  assign w_load   = w_accept && ((r_cnt == '0) || (mag_in > r_peak_mag));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (w_accept && (r_cnt == LAST_IDX)) w_next = S_DONE;
      S_DONE:    if (out_ready) w_next = S_IDLE;  // a start here is dropped
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
    end else if (w_arm) begin
      r_cnt      <= '0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
    end else if (w_accept) begin
      // The counter leaves COLLECT on its last value, so any wrap at
      // FRAME_LEN == 2**IDX_W is never observed; the next start clears it.
      r_cnt <= r_cnt + IDX_W'(1);
      if (w_load) begin
        r_peak_mag <= mag_in;
        r_peak_idx <= r_cnt;
      end
    end
  end

`ifdef MAG_THRESH_EN
  logic [IDX_W:0] r_over_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_over_cnt <= '0;
    else if (w_arm)
      r_over_cnt <= '0;
    else if (w_accept && (mag_in >= thresh))
      r_over_cnt <= r_over_cnt + (IDX_W+1)'(1);
  end

  assign over_cnt = r_over_cnt;
`endif

  assign in_ready   = (r_state == S_COLLECT);
  assign peak_valid = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign peak_mag   = r_peak_mag;
  assign peak_idx   = r_peak_idx;

endmodule

// File: tb/tb_mag_peak_detector.sv
module tb_mag_peak_detector;

  localparam int DW = 16;
  localparam int FL = 4;
  localparam int IW = 6;

  logic          clk, rst_n, start, in_valid, in_ready, peak_valid, out_ready, busy;
  logic [DW-1:0] mag_in, peak_mag;
  logic [IW-1:0] peak_idx;
  logic [DW-1:0] thresh;
  logic [IW:0]   over_cnt;

  int tests = 0;
  int fails = 0;

  mag_peak_detector #(.DATA_W(DW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mag_in(mag_in),
    .in_valid(in_valid), .in_ready(in_ready), .peak_mag(peak_mag),
    .peak_idx(peak_idx), .peak_valid(peak_valid), .out_ready(out_ready),
`ifdef MAG_THRESH_EN
    .thresh(thresh), .over_cnt(over_cnt),
`endif
    .busy(busy)
  );

`ifndef MAG_THRESH_EN
  assign over_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] m [FL];
    bit            stall;
    int            hold;
    logic [DW-1:0] exp_mag;
    logic [IW-1:0] exp_idx;
    int            exp_over;   // count of samples >= 5
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < FL; i++) begin
      if (v.stall) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      mag_in   = v.m[i];
      @(negedge clk);
      if (i < FL-1) chk({tag, " early valid"}, 32'(peak_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk({tag, " peak_valid"}, 32'(peak_valid), 32'd1);
    chk({tag, " peak_mag"}, 32'(peak_mag), 32'(v.exp_mag));
    chk({tag, " peak_idx"}, 32'(peak_idx), 32'(v.exp_idx));
`ifdef MAG_THRESH_EN
    chk({tag, " over_cnt"}, 32'(over_cnt), 32'(v.exp_over));
`endif
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(peak_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk({tag, " drained valid"}, 32'(peak_valid), 32'd0);
    chk({tag, " drained busy"}, 32'(busy), 32'd0);
    chk({tag, " idle peak_mag"}, 32'(peak_mag), 32'(v.exp_mag));
  endtask

  initial begin
    vecs[0] = '{m:'{16'd3, 16'd9, 16'd9, 16'd2},    stall:0, hold:0, exp_mag:16'd9,    exp_idx:6'd1, exp_over:2};
    vecs[1] = '{m:'{16'd0, 16'd0, 16'd0, 16'd0},    stall:0, hold:0, exp_mag:16'd0,    exp_idx:6'd0, exp_over:0};
    vecs[2] = '{m:'{16'd1, 16'd2, 16'd3, 16'hFFFF}, stall:0, hold:0, exp_mag:16'hFFFF, exp_idx:6'd3, exp_over:1};
    vecs[3] = '{m:'{16'd3, 16'd9, 16'd9, 16'd2},    stall:1, hold:5, exp_mag:16'd9,    exp_idx:6'd1, exp_over:2};
    vecs[4] = '{m:'{16'd4, 16'd5, 16'd6, 16'd5},    stall:0, hold:1, exp_mag:16'd6,    exp_idx:6'd2, exp_over:3};
    vecs[5] = '{m:'{16'd7, 16'd2, 16'd8, 16'd8},    stall:0, hold:0, exp_mag:16'd8,    exp_idx:6'd2, exp_over:3};
    vecs[6] = '{m:'{16'd10, 16'd1, 16'd1, 16'd1},   stall:1, hold:0, exp_mag:16'd10,   exp_idx:6'd0, exp_over:1};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mag_in = '0; thresh = 16'd5;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst peak_valid", 32'(peak_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst peak_mag", 32'(peak_mag), 32'd0);
    chk("rst peak_idx", 32'(peak_idx), 32'd0);
    rst_n = 1'b1;

    // Samples offered in IDLE without start are not taken.
    in_valid = 1'b1; mag_in = 16'd50;
    repeat (2) @(negedge clk);
    chk("idle no accept", 32'(in_ready), 32'd0);
    chk("idle not busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    for (int k = 0; k < 7; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

    // start mid-frame is ignored: the counter keeps going from 2.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; mag_in = 16'd5; @(negedge clk);
    mag_in = 16'd6; @(negedge clk);
    in_valid = 1'b0; start = 1'b1; @(negedge clk);
    start = 1'b0;
    chk("midstart busy", 32'(busy), 32'd1);
    in_valid = 1'b1; mag_in = 16'd1; @(negedge clk);
    mag_in = 16'd2; @(negedge clk);
    in_valid = 1'b0;
    chk("midstart valid", 32'(peak_valid), 32'd1);
    chk("midstart mag", 32'(peak_mag), 32'd6);
    chk("midstart idx", 32'(peak_idx), 32'd1);

    // start together with out_ready in DONE: back to IDLE only.
    start = 1'b1; out_ready = 1'b1; @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk("done+start valid", 32'(peak_valid), 32'd0);
    @(negedge clk);
    chk("done+start not armed", 32'(in_ready), 32'd0);
    chk("done+start busy", 32'(busy), 32'd0);

    // Reset after 2 samples aborts the frame.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1; mag_in = 16'd100; @(negedge clk);
    mag_in = 16'd200; @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort peak_mag", 32'(peak_mag), 32'd0);
    chk("abort peak_idx", 32'(peak_idx), 32'd0);
    chk("abort valid", 32'(peak_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_frame(vecs[0], "post-abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
